// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) trinomial reduction slice.
//   GF_M, GF_K  : default field degree and trinomial middle exponent
//   state_e     : reducer FSM states
//   fold_count  : number of fold cycles needed to clear m high bits, w per cycle
package gf2m_pkg;

    localparam int GF_M = 521;
    localparam int GF_K = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int fold_count(input int m, input int w);
        return (m + w - 1) / w;
    endfunction

endpackage

// File: rtl/gf2m_fold_slice.sv
// One reduction step: folds the chunk acc[ptr:lo], lo = max(ptr-FOLD_W+1, M),
// modulo x^M + x^K + 1. Purely combinational.
//   acc_i  : current 2M-bit accumulator
//   ptr_i  : top bit index of the chunk to fold
//   acc_o  : accumulator with the chunk folded down
//   ptr_o  : top index of the next chunk (lo-1)
module gf2m_fold_slice
    import gf2m_pkg::*;
#(
    parameter int M      = GF_M,
    parameter int K      = GF_K,
    parameter int FOLD_W = 131,
    parameter int PTR_W  = $clog2(2 * M)
) (
    input  logic [2*M-1:0]   acc_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [2*M-1:0]   acc_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [2*M-1:0] chunk_mask;
    logic [2*M-1:0] chunk;
    int             lo;

    // Because FOLD_W <= M-K, every toggled position (p-M+K, p-M) lies below lo,
    // so all chunk bits can be folded in parallel from the unmodified acc_i;
    // bits landing at >= M are picked up by a later chunk.
    always_comb begin
        lo = int'(ptr_i) - FOLD_W + 1;
        if (lo < M) begin
            lo = M;
        end
        for (int i = 0; i < 2 * M; i++) begin
            chunk_mask[i] = (i >= lo) && (i <= int'(ptr_i));
        end
        chunk = acc_i & chunk_mask;
        acc_o = (acc_i ^ chunk) ^ (chunk >> (M - K)) ^ (chunk >> M);
        ptr_o = PTR_W'(lo - 1);
    end

endmodule

// File: rtl/gf2m_trinomial_reduce.sv
// Sequential reducer: in_c mod (x^M + x^K + 1), FOLD_W high bits per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_c holds a 2M-bit unreduced product
//   in_ready   : idle, product will be accepted
//   in_c       : unreduced product
//   out_valid  : out_r holds the reduced element (held until out_ready)
//   out_ready  : consumer accepts out_r
//   out_r      : reduced M-bit field element
//   busy       : folding or waiting for the consumer
module gf2m_trinomial_reduce
    import gf2m_pkg::*;
#(
    parameter int M      = GF_M,
    parameter int K      = GF_K,
    parameter int FOLD_W = 131
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-1:0] in_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_r,
    output logic           busy
);

    localparam int N_FOLD = fold_count(M, FOLD_W);
    localparam int PTR_W  = $clog2(2 * M);
    localparam int CNT_W  = (N_FOLD > 1) ? $clog2(N_FOLD) : 1;

    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(2 * M - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FOLD - 1);

    if (K < 1 || K >= M) begin : g_bad_k
        $error("gf2m_trinomial_reduce: K must satisfy 1 <= K < M");
    end
    if (FOLD_W < 1 || FOLD_W > M - K) begin : g_bad_fold_w
        $error("gf2m_trinomial_reduce: FOLD_W must satisfy 1 <= FOLD_W <= M-K");
    end

    state_e             state_q, state_d;
    logic [2*M-1:0]     acc_q, acc_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*M-1:0]     fold_acc;
    logic [PTR_W-1:0]   fold_ptr;

    gf2m_fold_slice #(
        .M      (M),
        .K      (K),
        .FOLD_W (FOLD_W),
        .PTR_W  (PTR_W)
    ) u_fold (
        .acc_i (acc_q),
        .ptr_i (ptr_q),
        .acc_o (fold_acc),
        .ptr_o (fold_ptr)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps this process free of latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = FOLD;
            FOLD:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Outputs. out_r is gated so it only shows the finished result.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == FOLD) || (state_q == DONE);
        out_r     = (state_q == DONE) ? acc_q[M-1:0] : '0;
    end

    // Datapath next-state: load, fold one chunk per cycle, clear on hand-off.
    always_comb begin
        acc_d = acc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = in_c;
                    ptr_d = PTR_TOP;
                    cnt_d = '0;
                end
            end
            FOLD: begin
                acc_d = fold_acc;
                ptr_d = fold_ptr;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    acc_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gf2m_trinomial_reduce.sv
// Scoreboard bench for gf2m_trinomial_reduce (M=521, K=32, FOLD_W=131).
// Stimulus pushes expected results into exp_q; the monitor pops and compares
// on every output handshake.
module tb_gf2m_trinomial_reduce;

    localparam int M  = 521;
    localparam int K  = 32;
    localparam int FW = 131;
    localparam int W  = 2 * M;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_c;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   out_r;
    logic           busy;

    logic [M-1:0]   exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    bit             rand_rdy = 1'b0;

    gf2m_trinomial_reduce #(
        .M      (M),
        .K      (K),
        .FOLD_W (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, M'(act), M'(exp));
    endtask

    // Bit-serial reference: clear each high bit from the top, toggling p-M+K and p-M.
    function automatic logic [M-1:0] model(input logic [W-1:0] c);
        logic [W-1:0] a;
        a = c;
        for (int p = W - 1; p >= M; p--) begin
            if (a[p]) begin
                a[p]         = 1'b0;
                a[p - M + K] = ~a[p - M + K];
                a[p - M]     = ~a[p - M];
            end
        end
        return a[M-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] c;
        c = '0;
        repeat ((W + 31) / 32) c = {c[W-33:0], 32'($urandom)};
        return c;
    endfunction

    // Monitor: compares on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_r, '0);
            end else begin
                check("scoreboard", out_r, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1. Returns at posedge+1 of the accepting edge.
    task automatic send(input logic [W-1:0] c, input logic [M-1:0] exp, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_c     = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check_bit("accept_timeout", in_ready, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_bit("drain", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] c, x;
        logic [M-1:0] e, e_rand;
        bit           seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_c      = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check("rst_out_r", out_r, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: x^521 -> x^32 + 1, out_valid exactly 4 edges after acceptance
        c = '0; c[521] = 1'b1;
        e = '0; e[32] = 1'b1; e[0] = 1'b1;
        send(c, e, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_bit($sformatf("latency_%0d", k), out_valid, k == 5);
        end
        @(posedge clk);
        #1;
        wait_drain();

        // 3: x^1041 -> bits 520, 63, 31 (folded bit 552 caught by later chunk)
        c = '0; c[1041] = 1'b1;
        e = '0; e[520] = 1'b1; e[63] = 1'b1; e[31] = 1'b1;
        send(c, e, 1'b1);
        wait_drain();

        // 4: small operand passes through; backpressure for 10 cycles with a
        // pending new input (2: x^1040 -> bits 519, 62, 30) that must not be taken
        out_ready = 1'b0;
        c = rand_wide();
        c[W-1:M] = '0;
        e_rand = c[M-1:0];
        send(c, e_rand, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_bit("bp_out_valid_rise", seen, 1'b1);
        @(posedge clk);
        #1;
        x = '0; x[1040] = 1'b1;
        in_valid = 1'b1;
        in_c     = x;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_bit("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_out_r", out_r, e_rand);
            check_bit("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        e = '0; e[519] = 1'b1; e[62] = 1'b1; e[30] = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("done_no_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("accept_after_done", busy, 1'b1);
        wait_drain();

        // 5: asynchronous reset during the second FOLD cycle
        c = '0; c[521] = 1'b1;
        send(c, '0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        e = '0; e[32] = 1'b1; e[0] = 1'b1;
        send(c, e, 1'b1);
        wait_drain();

        // 6: random products back-to-back with random out_ready, then all-ones
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            c = rand_wide();
            send(c, model(c), 1'b1);
        end
        c = '1;
        send(c, model(c), 1'b1);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        check("queue_empty", M'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf2m_trinomial_reduce.md
# gf2m_trinomial_reduce

Sequential reducer for binary-field (GF(2^M)) polynomial products. It sits directly downstream of the four-way Toom-Cook carry-less multiplier. It takes the 2M-bit unreduced product and folds it modulo the irreducible trinomial x^M + x^K + 1, processing FOLD_W high-order bits per cycle. It returns the M-bit field element over a valid/ready handshake, so multiplier results can feed field arithmetic without a wide single-cycle reduction tree.

## Interface
- M, default 521: field degree; output width.
- K, default 32: middle exponent of the trinomial x^M + x^K + 1.
- FOLD_W, default 131: high bits folded per cycle; legal range 1 ≤ FOLD_W ≤ M−K.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_c holds a product to reduce.
- in_ready  output  1  block is idle and can accept; high when state is IDLE.
- in_c  input  2M  unreduced product; matches the multiplier output width. Bit 2M−1 is legal and is reduced.
- out_valid  output  1  out_r holds a reduced result.
- out_ready  input  1  consumer accepts out_r.
- out_r  output  M  in_c mod (x^M + x^K + 1).
- busy  output  1  state is FOLD or DONE.

## Operation
- Internal state:
  - acc: register of 2M bits.
  - ptr: top index of the current chunk.
  - cnt: fold counter.
  - FSM with three states: IDLE, FOLD, DONE.
- N_FOLD = ceil(M / FOLD_W). With the defaults this is 4.
- IDLE:
  - in_ready = 1.
  - On in_valid: acc ← in_c, ptr ← 2M−1, cnt ← 0, go to FOLD.
- FOLD: one chunk per cycle.
  - Chunk is bits ptr down to lo = max(ptr−FOLD_W+1, M).
  - For every set bit p in the chunk: clear bit p, toggle bit p−M+K, toggle bit p−M.
  - Then ptr ← lo−1 and cnt ← cnt+1. When cnt reaches N_FOLD−1, go to DONE.
- Correctness rule: FOLD_W ≤ M−K guarantees every toggled bit lies below lo. Bits that land at ≥ M are therefore covered by a later chunk.
- DONE:
  - out_valid = 1; out_r = acc[M−1:0], stable while out_valid is high.
  - On out_ready: go to IDLE and clear acc.
- Arithmetic is GF(2) only: XOR, no carries.
- Elaboration error if K < 1, K ≥ M, FOLD_W < 1 or FOLD_W > M−K.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_r = 0, busy = 0. acc, ptr and cnt are cleared.
- Latency: input accepted at edge E; out_valid rises at edge E+N_FOLD (E+4 with the defaults). The latency does not depend on the data.
- Throughput: at most one operation per N_FOLD+2 cycles.
- in_ready is low in FOLD and DONE. An input offered during those states is not sampled, and the producer must hold it.
- Backpressure: out_ready low in DONE holds out_valid and out_r indefinitely.
- Reset mid-operation: rst in FOLD or DONE immediately drops out_valid and busy and raises in_ready. The partial result is discarded.
- in_valid and out_ready high in the same DONE cycle: only the output handshake completes. The new input is accepted on the next cycle, from IDLE.

## Structure
- Shared package gf2m_pkg holds:
  - constants GF_M = 521 and GF_K = 32;
  - function fold_count(m, w) returning ceil(m/w);
  - state enum {IDLE, FOLD, DONE}.
- One sub-module, gf2m_fold_slice: combinational.
  - Inputs: acc and ptr.
  - Output: acc after folding the chunk starting at ptr.
  - The top level holds only the FSM, the counters and the handshake.

## Test plan
All scenarios use the defaults M=521, K=32, FOLD_W=131.
1. in_c = 2^521 → out_r = 2^32 + 1; out_valid rises exactly 4 edges after acceptance.
2. in_c = 2^1040 → out_r has bits 519, 62, 30 set.
3. in_c = 2^1041 → out_r has bits 520, 63, 31 set. This checks a folded bit ≥ M being caught by a later chunk.
4. Random in_c < 2^521 with out_ready held low for 10 cycles → out_r = in_c[520:0] and stays stable; in_ready stays 0; no second acceptance.
5. rst pulsed asynchronously during the second FOLD cycle → out_valid = 0 and in_ready = 1 immediately. The next operation, in_c = 2^521, then yields 2^32 + 1.
6. 1000 random 1042-bit products, plus all-ones, sent back-to-back with random out_ready → every out_r matches the software trinomial-reduction model.
